// File: rtl/ks_pkg.sv
// ks_pkg: shared types, parameter limits and elaboration helpers for the
// pipelined Kogge-Stone adder.
package ks_pkg;

   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 64;
   localparam int PIPE_MIN  = 0;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int ks_levels(input int width);
      int n;
      n = 0;
      for (int w = 1; w < width; w = w * 2) n++;
      return n;
   endfunction

   // ceil(k*levels/(stages+1)) in integer arithmetic
   function automatic int stage_after_level(input int k, input int stages, input int levels);
      return (k * levels + stages) / (stages + 1);
   endfunction

   function automatic bit level_has_reg(input int level, input int stages, input int levels);
      bit hit;
      hit = 1'b0;
      for (int k = 1; k <= stages; k++)
         if (stage_after_level(k, stages, levels) == level) hit = 1'b1;
      return hit;
   endfunction

   function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/ks_adder_pipe_level.sv
// ks_prefix_level: one Kogge-Stone (G,P) merge level at distance DIST, with an
// optional elastic register stage (REG=1) carrying data and a valid bit.
module ks_prefix_level
   import ks_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIST  = 1,
   parameter bit REG   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] g_i,
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] pb_i,
   input  logic             cin_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] g_o,
   output logic [WIDTH-1:0] p_o,
   output logic [WIDTH-1:0] pb_o,
   output logic             cin_o
);

   gp_t  [WIDTH-1:0] gp_d;
   logic [WIDTH-1:0] g_d;
   logic [WIDTH-1:0] p_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_merge
         assign gp_d[i] = gp_merge({g_i[i], p_i[i]}, {g_i[i-DIST], p_i[i-DIST]});
      end else begin : g_pass
         assign gp_d[i] = {g_i[i], p_i[i]};
      end
      assign g_d[i] = gp_d[i].g;
      assign p_d[i] = gp_d[i].p;
   end

   if (REG) begin : g_reg
      logic             valid_q;
      logic             cin_q;
      logic [WIDTH-1:0] g_q;
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] pb_q;
      assign ready_o = !valid_q || ready_i;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            cin_q   <= 1'b0;
            g_q     <= '0;
            p_q     <= '0;
            pb_q    <= '0;
         end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
               cin_q <= cin_i;
               g_q   <= g_d;
               p_q   <= p_d;
               pb_q  <= pb_i;
            end
         end
      end
      assign valid_o = valid_q;
      assign g_o     = g_q;
      assign p_o     = p_q;
      assign pb_o    = pb_q;
      assign cin_o   = cin_q;
   end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign ready_o    = ready_i;
      assign valid_o    = valid_i;
      assign g_o        = g_d;
      assign p_o        = p_d;
      assign pb_o       = pb_i;
      assign cin_o      = cin_i;
   end

endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: elastic pipelined Kogge-Stone adder with multi-word carry chaining.
// Define KS_OVERFLOW_EN to add the registered signed-overflow output out_ovf.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int PIPE_STAGES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
`ifdef KS_OVERFLOW_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int LEVELS = ks_levels(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH & (WIDTH - 1)) != 0 ||
       PIPE_STAGES < PIPE_MIN || PIPE_STAGES > LEVELS) begin : g_bad_param
      $error("ks_adder_pipe: unsupported WIDTH/PIPE_STAGES combination");
   end

   logic [WIDTH-1:0] g   [0:LEVELS];
   logic [WIDTH-1:0] p   [0:LEVELS];
   logic [WIDTH-1:0] pb  [0:LEVELS];
   logic             ci  [0:LEVELS];
   logic             v   [0:LEVELS];
   logic             rdy [0:LEVELS];
   logic [LEVELS-1:0] occ;
   logic             carry_q;
   logic             cin_sel;
   logic             load;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             out_valid_q;
   logic             out_cout_q;
   logic [WIDTH-1:0] out_sum_q;
   logic             unused_p;

   // A chained word may only enter once no earlier word is still in the prefix stages
   assign cin_sel  = in_first ? in_cin : carry_q;
   assign in_ready = rdy[0] && (in_first || !(|occ));
   assign pb[0]    = in_a ^ in_b;
   assign g[0]     = (in_a & in_b) | {{(WIDTH-1){1'b0}}, (in_a[0] ^ in_b[0]) & cin_sel};
   assign p[0]     = {pb[0][WIDTH-1:1], 1'b0};
   assign ci[0]    = cin_sel;
   assign v[0]     = in_valid && in_ready;

   for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
      localparam bit R = level_has_reg(j + 1, PIPE_STAGES, LEVELS);
      ks_prefix_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << j),
         .REG   (R)
      ) u_lvl (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid_i (v[j]),
         .ready_o (rdy[j]),
         .g_i     (g[j]),
         .p_i     (p[j]),
         .pb_i    (pb[j]),
         .cin_i   (ci[j]),
         .valid_o (v[j+1]),
         .ready_i (rdy[j+1]),
         .g_o     (g[j+1]),
         .p_o     (p[j+1]),
         .pb_o    (pb[j+1]),
         .cin_o   (ci[j+1])
      );
      assign occ[j] = R & v[j+1];
   end

   assign rdy[LEVELS] = !out_valid_q || out_ready;
   assign sum_d       = pb[LEVELS] ^ {g[LEVELS][WIDTH-2:0], ci[LEVELS]};
   assign cout_d      = g[LEVELS][WIDTH-1];
   assign load        = rdy[LEVELS] && v[LEVELS];
   assign unused_p    = ^p[LEVELS];

`ifdef KS_OVERFLOW_EN
   logic out_ovf_q;
   assign out_ovf = out_ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         carry_q     <= 1'b0;
`ifdef KS_OVERFLOW_EN
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         if (rdy[LEVELS]) out_valid_q <= v[LEVELS];
         if (load) begin
            out_sum_q  <= sum_d;
            out_cout_q <= cout_d;
            carry_q    <= cout_d;
`ifdef KS_OVERFLOW_EN
            out_ovf_q  <= g[LEVELS][WIDTH-1] ^ g[LEVELS][WIDTH-2];
`endif
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign busy      = (|occ) || out_valid_q;

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      in_valid && !in_ready |=> in_valid && $stable({in_a, in_b, in_cin, in_first}));

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: directed self-checking bench for ks_adder_pipe (WIDTH=8, PIPE_STAGES=1);
// the out_ovf scenario is compiled in when KS_OVERFLOW_EN is defined.
module tb_ks_adder_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_cin;
   logic       in_first;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_cout;
   logic       busy;
`ifdef KS_OVERFLOW_EN
   logic       out_ovf;
   logic       ovf_q[$];
`endif
   logic [8:0] got_q[$];
   int         errs = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   ks_adder_pipe #(.WIDTH(8), .PIPE_STAGES(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_first  (in_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
`ifdef KS_OVERFLOW_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   // Capture every result accepted downstream, in order
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back({out_cout, out_sum});
`ifdef KS_OVERFLOW_EN
         ovf_q.push_back(out_ovf);
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic first);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_first = first;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the handshake edge
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic first, output int stalls);
      drive(a, b, cin, first);
      stalls = 0;
      #1;
      while (!in_ready && stalls < 20) begin
         @(posedge clk); #2;
         stalls++;
      end
      if (!in_ready) begin
         checks++; errs++;
         $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_results(input int n);
      for (int w = 0; w < 30 && got_q.size() < n; w++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (got_q.size() != n) begin
         errs++;
         $display("FAIL result_count: got %0d results, required %0d", got_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_first = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_cout, out_sum, busy} !== 11'h000) begin
         errs++;
         $display("FAIL reset_state: valid/cout/sum/busy=%b/%b/%h/%b, required 0/0/00/0", out_valid, out_cout, out_sum, busy);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      drive(8'hFF, 8'h01, 1'b0, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errs++; $display("FAIL lat_in_ready: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, busy} !== 2'b01) begin
         errs++; $display("FAIL lat_cycle1: valid/busy=%b/%b, required 0/1", out_valid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_cout, out_sum} !== 10'h300) begin
         errs++; $display("FAIL lat_cycle2: valid/cout/sum=%b/%b/%h, required 1/1/00", out_valid, out_cout, out_sum);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errs++; $display("FAIL lat_drain: valid/busy=%b/%b, required 0/0", out_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_q [256];
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      got_q.delete();
      for (int n = 0; n < 258; n++) begin
         if (n < 256) begin
            a = 8'(n * 37 + 11);
            b = 8'(n * 101 + 7);
            c = (n % 3) == 0;
            exp_q[n] = 9'({1'b0, a} + {1'b0, b} + {8'h00, c});
            drive(a, b, c, 1'b1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (n < 256) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errs++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", n, in_ready);
            end
         end
         if (n >= 2) begin
            checks++;
            if ({out_valid, out_cout, out_sum} !== {1'b1, exp_q[n-2]}) begin
               errs++;
               $display("FAIL b2b_result[%0d]: valid/cout/sum=%b/%b/%h, required 1/%b/%h",
                        n - 2, out_valid, out_cout, out_sum, exp_q[n-2][8], exp_q[n-2][7:0]);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b0 || got_q.size() != 256) begin
         errs++; $display("FAIL b2b_tail: out_valid=%b results=%0d, required 0 and 256", out_valid, got_q.size());
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(8'hA1, 8'h02, 1'b0, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errs++; $display("FAIL bp_ready0: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      drive(8'h33, 8'h44, 1'b1, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errs++; $display("FAIL bp_ready1: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      drive(8'h90, 8'h90, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if ({in_ready, out_valid, out_cout, out_sum} !== 11'h2A3) begin
            errs++;
            $display("FAIL bp_hold[%0d]: in_ready/valid/cout/sum=%b/%b/%b/%h, required 0/1/0/a3",
                     k, in_ready, out_valid, out_cout, out_sum);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, out_cout, out_sum} !== 11'h6A3) begin
         errs++; $display("FAIL bp_release: in_ready/valid/cout/sum=%b/%b/%b/%h, required 1/1/0/a3", in_ready, out_valid, out_cout, out_sum);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_cout, out_sum} !== 10'h278) begin
         errs++; $display("FAIL bp_second: valid/cout/sum=%b/%b/%h, required 1/0/78", out_valid, out_cout, out_sum);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_cout, out_sum} !== 10'h320) begin
         errs++; $display("FAIL bp_third: valid/cout/sum=%b/%b/%h, required 1/1/20", out_valid, out_cout, out_sum);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errs++; $display("FAIL bp_nodup: valid/busy=%b/%b, required 0/0", out_valid, busy);
      end
   endtask

   task automatic test_chain();
      logic [7:0] a_tab [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hCD, 8'hAB, 8'h34, 8'h12};
      logic [7:0] b_tab [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h43, 8'h65, 8'h0F, 8'h0F};
      logic [8:0] e_tab [8] = '{9'h100, 9'h100, 9'h100, 9'h100, 9'h110, 9'h111, 9'h044, 9'h021};
      int         stalls;
      got_q.delete();
      for (int n = 0; n < 8; n++) begin
         send(a_tab[n], b_tab[n], 1'b0, (n % 4) == 0, stalls);
         checks++;
         if (stalls != ((n % 4) == 0 ? 0 : 1)) begin
            errs++; $display("FAIL chain_stall[%0d]: got %0d stall cycles, required %0d", n, stalls, (n % 4) == 0 ? 0 : 1);
         end
      end
      wait_results(8);
      for (int n = 0; n < 8 && n < got_q.size(); n++) begin
         checks++;
         if (got_q[n] !== e_tab[n]) begin
            errs++; $display("FAIL chain_word[%0d]: cout/sum=%b/%h, required %b/%h", n, got_q[n][8], got_q[n][7:0], e_tab[n][8], e_tab[n][7:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int stalls;
      got_q.delete();
      send(8'hFF, 8'h01, 1'b0, 1'b1, stalls);
      send(8'hFF, 8'hFF, 1'b0, 1'b1, stalls);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errs++; $display("FAIL rst_mid: valid/busy=%b/%b, required 0/0", out_valid, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(8'h10, 8'h20, 1'b1, 1'b0, stalls);
      checks++;
      if (stalls != 0) begin
         errs++; $display("FAIL rst_chain_stall: got %0d stall cycles, required 0", stalls);
      end
      wait_results(1);
      checks++;
      if (got_q.size() < 1 || got_q[0] !== 9'h030) begin
         errs++; $display("FAIL rst_carry_clear: cout/sum=%h, required 030", got_q.size() > 0 ? got_q[0] : 9'h1FF);
      end
   endtask

`ifdef KS_OVERFLOW_EN
   task automatic test_ovf();
      logic [7:0] a_tab [3] = '{8'h7F, 8'h80, 8'hFF};
      logic [7:0] b_tab [3] = '{8'h01, 8'h80, 8'h01};
      logic [9:0] e_tab [3] = '{10'h280, 10'h300, 10'h100};
      int         stalls;
      got_q.delete();
      ovf_q.delete();
      for (int n = 0; n < 3; n++) send(a_tab[n], b_tab[n], 1'b0, 1'b1, stalls);
      wait_results(3);
      for (int n = 0; n < 3 && n < got_q.size(); n++) begin
         checks++;
         if ({ovf_q[n], got_q[n]} !== e_tab[n]) begin
            errs++; $display("FAIL ovf[%0d]: ovf/cout/sum=%b/%b/%h, required %b/%b/%h", n, ovf_q[n], got_q[n][8], got_q[n][7:0], e_tab[n][9], e_tab[n][8], e_tab[n][7:0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_chain();
      test_reset_mid();
`ifdef KS_OVERFLOW_EN
      test_ovf();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
